// File: rtl/cog_vcap_pkg.sv
// cog_vcap_pkg: shared capture modes, cap field positions and pixels-per-word helper.
package cog_vcap_pkg;
  typedef enum logic [1:0] {OFF, B1, B2, B8} mode_t;
  localparam int MODE_LSB = 29;
  localparam int GRP_LSB  = 9;
  localparam int SEL_LSB  = 12;
  localparam int MASK_LSB = 0;
  function automatic logic [5:0] ppw(mode_t md);
    return md == B8 ? 6'd4 : md == B2 ? 6'd16 : md == B1 ? 6'd32 : 6'd0;
  endfunction
endpackage

// File: rtl/cog_vcap_sync.sv
// cog_vcap_sync: STAGES-deep 32-bit pin synchronizer, no reset.
//   clk_cog: clock, d: raw async pins, q: synchronized pins
module cog_vcap_sync #(
  parameter int STAGES = 2
) (
  input  logic        clk_cog,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] ff [STAGES];
  always_ff @(posedge clk_cog) begin
    ff[0] <= d;
    for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/cog_vcap.sv
// cog_vcap: per-cog video capture, packs sampled pin pixels LSB-first into 32-bit words.
//   clk_cog/nres: clock and sync active-low reset; ena: cog running
//   setcap/setscl/data: config and scale writes; getcap/ack/word: word handshake
//   pin_in: raw pins; ovf: sticky overrun
module cog_vcap
  import cog_vcap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        ena,
  input  logic        setcap,
  input  logic        setscl,
  input  logic [31:0] data,
  input  logic        getcap,
  input  logic [31:0] pin_in,
  output logic        ack,
  output logic [31:0] word,
  output logic        ovf
);
  logic [31:0] sp, sr, shifted;
  mode_t       mode;
  logic [1:0]  grp, px2;
  logic [2:0]  sel;
  logic [7:0]  mask, scl, cnt, m;
  logic [4:0]  pix;
  logic        strobe, last, unused_data;
  cog_vcap_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk_cog, .d(pin_in), .q(sp));
  assign m = sp[{grp, 3'b000} +: 8] & mask;
  assign px2 = m[{sel[2:1], 1'b0} +: 2];
  // cnt counts down to 1; a load of 0 wraps through 255 so scl=0 means 256 clocks
  assign strobe = mode != OFF && cnt == 8'd1;
  assign last = strobe && pix == 5'(ppw(mode) - 6'd1);
  assign shifted = mode == B8 ? {m, sr[31:8]} : mode == B2 ? {px2, sr[31:2]} : {m[sel], sr[31:1]};
  assign unused_data = ^{data[31], data[28:15], data[11], data[8]};
  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      mode <= OFF;
      grp  <= '0;
      sel  <= '0;
      mask <= '0;
      scl  <= '0;
      cnt  <= '0;
      pix  <= '0;
      sr   <= '0;
      word <= '0;
      ack  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (setscl) scl <= data[7:0];
      if (!ena) begin
        mode <= OFF;
        grp  <= '0;
        sel  <= '0;
        mask <= '0;
        cnt  <= '0;
        pix  <= '0;
        sr   <= '0;
        word <= '0;
        ack  <= 1'b0;
        ovf  <= 1'b0;
      end else if (setcap) begin
        mode <= mode_t'(data[MODE_LSB +: 2]);
        grp  <= data[GRP_LSB +: 2];
        sel  <= data[SEL_LSB +: 3];
        mask <= data[MASK_LSB +: 8];
        cnt  <= setscl ? data[7:0] : scl;
        pix  <= '0;
        sr   <= '0;
        ack  <= 1'b0;
        ovf  <= 1'b0;
      end else begin
        if (mode != OFF) cnt <= strobe ? scl : cnt - 8'd1;
        if (strobe) begin
          sr  <= shifted;
          pix <= last ? 5'd0 : pix + 5'd1;
        end
        // a completed word always lands; overrun only if the old one was not taken this cycle
        if (last) begin
          word <= shifted;
          ack  <= 1'b1;
          ovf  <= ovf | (ack & ~getcap);
        end else if (getcap && ack) ack <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cog_vcap.sv
// tb_cog_vcap: randomized and directed self-checking bench for cog_vcap against an event-time model.
module tb_cog_vcap;
  logic        clk_cog = 0, nres = 0, ena = 0, setcap = 0, setscl = 0, getcap = 0;
  logic [31:0] data = 0, pin_in = 0, word;
  logic        ack, ovf;
  int          n_chk = 0, n_bad = 0;
  bit          mon = 0;

  cog_vcap #(.SYNC_STAGES(2)) dut (
    .clk_cog(clk_cog), .nres(nres), .ena(ena), .setcap(setcap), .setscl(setscl),
    .data(data), .getcap(getcap), .pin_in(pin_in), .ack(ack), .word(word), .ovf(ovf)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wid(input logic [1:0] md);
    return md == 2'd3 ? 8 : md == 2'd2 ? 2 : 1;
  endfunction

  function automatic int per(input logic [7:0] s);
    return s == 8'd0 ? 256 : int'(s);
  endfunction

  // model: strobes happen at absolute cycle numbers; pixel n lands at bit n*w of the word
  int          cyc = 0, next_s = 0, npx = 0;
  logic [31:0] hist[$];
  logic [31:0] acc = 0, m_word = 0;
  logic        m_ack = 0, m_ovf = 0;
  logic [1:0]  m_mode = 0, m_grp = 0;
  logic [2:0]  m_sel = 0;
  logic [7:0]  m_mask = 0, m_scl = 0;

  always @(posedge clk_cog) begin
    logic [7:0]  old_scl, gm, px;
    logic [31:0] smp;
    bit          fin;
    int          w;
    hist.push_back(pin_in);
    if (!nres) begin
      m_mode = 0; m_grp = 0; m_sel = 0; m_mask = 0; m_scl = 0;
      npx = 0; acc = 0; m_word = 0; m_ack = 0; m_ovf = 0;
    end else begin
      old_scl = m_scl;
      if (setscl) m_scl = data[7:0];
      if (!ena) begin
        m_mode = 0; m_grp = 0; m_sel = 0; m_mask = 0;
        npx = 0; acc = 0; m_word = 0; m_ack = 0; m_ovf = 0;
      end else if (setcap) begin
        m_mode = data[30:29]; m_grp = data[10:9]; m_sel = data[14:12]; m_mask = data[7:0];
        next_s = cyc + per(m_scl);
        npx = 0; acc = 0; m_ack = 0; m_ovf = 0;
      end else begin
        fin = 0;
        if (m_mode != 0 && cyc == next_s) begin
          w = wid(m_mode);
          smp = hist[cyc-2];
          gm = smp[8*m_grp +: 8] & m_mask;
          px = w == 8 ? gm : w == 2 ? 8'((gm >> (2 * (m_sel >> 1))) & 8'd3) : 8'(gm[m_sel]);
          acc = acc | (32'(px) << (npx * w));
          npx++;
          next_s = cyc + per(old_scl);
          if (npx == 32 / w) fin = 1;
        end
        if (fin) begin
          if (m_ack && !getcap) m_ovf = 1;
          m_word = acc; m_ack = 1; acc = 0; npx = 0;
        end else if (getcap && m_ack) m_ack = 0;
      end
    end
    cyc++;
  end

  always @(negedge clk_cog) if (mon) begin
    chk("m_ack", 32'(ack), 32'(m_ack));
    chk("m_word", word, m_word);
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
  end

  task automatic cfg(input logic [1:0] md, input logic [1:0] g, input logic [7:0] mk,
                     input logic [2:0] sl, input logic [7:0] s);
    @(posedge clk_cog); #1;
    setscl = 1; data = {24'h0, s};
    @(posedge clk_cog); #1;
    setscl = 0; setcap = 1;
    data = {1'b0, md, 14'h0, sl, 1'b0, g, 1'b0, mk};
    @(posedge clk_cog); #1;
    setcap = 0;
  endtask

  task automatic feed(input logic [1:0] md, input logic [1:0] g, input logic [2:0] sl, input int s,
                      input logic [31:0] pat, input int n, input bit cons);
    int w, base;
    w = wid(md);
    base = 8 * g + (w == 1 ? int'(sl) : w == 2 ? 2 * int'(sl >> 1) : 0);
    for (int k = 0; k < n; k++) begin
      pin_in = $urandom;
      for (int b = 0; b < w; b++) pin_in[base+b] = pat[k*w+b];
      if (cons && k == n - 1) begin
        repeat (s - 1) @(posedge clk_cog);
        #1 getcap = 1;
        @(posedge clk_cog); #1;
        getcap = 0;
      end else begin
        repeat (s) @(posedge clk_cog);
        #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] p1, p2, p3;
    repeat (3) @(posedge clk_cog);
    #1 nres = 1; ena = 1; mon = 1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_word", word, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    cfg(2'd1, 2'd0, 8'hFF, 3'd0, 8'd4);
    feed(2'd1, 2'd0, 3'd0, 4, 32'hA5A5A5A5, 32, 0);
    chk("b1_ack", 32'(ack), 32'd1);
    chk("b1_word", word, 32'hA5A5A5A5);
    cfg(2'd1, 2'd0, 8'hFF, 3'd0, 8'd1);
    repeat (40) begin @(posedge clk_cog); #1 pin_in = $urandom; end
    chk("b1s1_ack", 32'(ack), 32'd1);
    cfg(2'd3, 2'd2, 8'hFF, 3'd0, 8'd3);
    feed(2'd3, 2'd2, 3'd0, 3, 32'h44332211, 4, 0);
    chk("b8_ack", 32'(ack), 32'd1);
    chk("b8_word", word, 32'h44332211);
    cfg(2'd2, 2'd0, 8'h0C, 3'd2, 8'd3);
    feed(2'd2, 2'd0, 3'd2, 3, 32'hFFFFFFFF, 16, 0);
    chk("b2_m0c", word, 32'hFFFFFFFF);
    cfg(2'd2, 2'd0, 8'h04, 3'd2, 8'd3);
    feed(2'd2, 2'd0, 3'd2, 3, 32'hFFFFFFFF, 16, 0);
    chk("b2_m04", word, 32'h55555555);
    p1 = $urandom; p2 = $urandom;
    cfg(2'd3, 2'd1, 8'hFF, 3'd0, 8'd3);
    feed(2'd3, 2'd1, 3'd0, 3, p1, 4, 0);
    chk("ovr_first_ovf", 32'(ovf), 32'd0);
    feed(2'd3, 2'd1, 3'd0, 3, p2, 4, 0);
    chk("ovr_ovf", 32'(ovf), 32'd1);
    chk("ovr_word", word, p2);
    getcap = 1;
    @(posedge clk_cog); #1 getcap = 0;
    chk("cons_ack", 32'(ack), 32'd0);
    chk("cons_ovf_sticky", 32'(ovf), 32'd1);
    cfg(2'd3, 2'd1, 8'hFF, 3'd0, 8'd3);
    chk("setcap_ovf", 32'(ovf), 32'd0);
    p1 = $urandom; p2 = $urandom;
    feed(2'd3, 2'd1, 3'd0, 3, p1, 4, 0);
    feed(2'd3, 2'd1, 3'd0, 3, p2, 4, 1);
    chk("coin_ack", 32'(ack), 32'd1);
    chk("coin_ovf", 32'(ovf), 32'd0);
    chk("coin_word", word, p2);
    p1 = $urandom; p2 = $urandom; p3 = $urandom;
    cfg(2'd1, 2'd0, 8'hFF, 3'd0, 8'd3);
    feed(2'd1, 2'd0, 3'd0, 3, p1, 32, 0);
    feed(2'd1, 2'd0, 3'd0, 3, p2, 10, 0);
    nres = 0;
    @(posedge clk_cog); #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_word", word, 32'd0);
    nres = 1;
    cfg(2'd1, 2'd0, 8'hFF, 3'd0, 8'd3);
    feed(2'd1, 2'd0, 3'd0, 3, p3, 32, 0);
    chk("recap_word", word, p3);
    chk("recap_ack", 32'(ack), 32'd1);
    cfg(2'd3, 2'd0, 8'hFF, 3'd0, 8'd0);
    repeat (1023) @(posedge clk_cog);
    #1 chk("scl0_early", 32'(ack), 32'd0);
    @(posedge clk_cog);
    #1 chk("scl0_ack", 32'(ack), 32'd1);
    cfg(2'd1, 2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom), 8'd2);
    repeat (4000) begin
      @(posedge clk_cog); #1;
      pin_in = $urandom;
      getcap = $urandom_range(0, 5) == 0;
      setcap = 0; setscl = 0;
      ena = $urandom_range(0, 299) != 0;
      case ($urandom_range(0, 149))
        0: begin setcap = 1; data = {1'b0, 2'($urandom_range(1, 3)), 29'($urandom)}; end
        1: begin setscl = 1; data = {24'($urandom), 8'($urandom_range(1, 5))}; end
        default: ;
      endcase
    end
    @(posedge clk_cog); #1;
    setcap = 0; setscl = 0; getcap = 0; ena = 1;
    @(negedge clk_cog);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
